// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants and gray-code helpers for the async FIFO
package fifo_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 4;
    localparam int PTR_W  = ADDR_W + 1;
    localparam int DEPTH  = 1 << ADDR_W;

    // 32-bit wide so any pointer width up to 32 can zero-extend in and truncate out
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b = g;
        for (int i = 1; i < 32; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer with synchronous active-low reset
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// rtl/fifo_rd_ctrl.sv - read-side controller of the gray-pointer async FIFO
module fifo_rd_ctrl #(
    parameter int ADDR_W = fifo_pkg::ADDR_W,
    parameter int DATA_W = fifo_pkg::DATA_W
) (
    input  logic              rd_clk,
    input  logic              rst_,
    input  logic [ADDR_W:0]   wr_ptr_gray,
    output logic [ADDR_W:0]   rd_ptr_gray,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W:0]   rd_level
);

    import fifo_pkg::bin2gray;
    import fifo_pkg::gray2bin;

    localparam int PTR_W = ADDR_W + 1;

    logic [PTR_W-1:0]  wq2_gray;
    logic [PTR_W-1:0]  wq2_bin;
    logic [PTR_W-1:0]  rd_ptr_bin;
    logic [PTR_W-1:0]  rd_ptr_next;
    logic              inflight;
    logic              mem_empty;
    logic              issue;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] obuf [2];
    logic              obuf_head;
    logic              obuf_tail;
    logic [1:0]        obuf_cnt;

    sync_2ff #(.W(PTR_W)) u_wptr_sync (
        .clk    (rd_clk),
        .resetn (rst_),
        .d      (wr_ptr_gray),
        .q      (wq2_gray)
    );

    assign wq2_bin   = PTR_W'(gray2bin(32'(wq2_gray)));
    assign mem_empty = (rd_ptr_bin == wq2_bin);
    assign out_valid = (obuf_cnt != 2'd0);
    assign pop       = out_valid && out_ready;
    assign push      = inflight;

    // Buffered plus in-flight words never exceed the two buffer slots, except
    // when a pop this cycle frees one for the word that lands next cycle.
    assign issue = !mem_empty &&
                   ((({1'b0, obuf_cnt} + {2'b00, inflight}) < 3'd2) || pop);

    assign rd_ptr_next = rd_ptr_bin + PTR_W'(issue);
    assign mem_rd_en   = issue;
    assign mem_rd_addr = rd_ptr_bin[ADDR_W-1:0];
    assign out_data    = obuf[obuf_head];
    assign rd_level    = wq2_bin - rd_ptr_bin;

    always_ff @(posedge rd_clk) begin
        if (!rst_) begin
            rd_ptr_bin  <= '0;
            rd_ptr_gray <= '0;
            inflight    <= 1'b0;
            obuf_head   <= 1'b0;
            obuf_tail   <= 1'b0;
            obuf_cnt    <= 2'd0;
            obuf[0]     <= '0;
            obuf[1]     <= '0;
        end else begin
            rd_ptr_bin  <= rd_ptr_next;
            rd_ptr_gray <= PTR_W'(bin2gray(32'(rd_ptr_next)));
            inflight    <= issue;
            if (push) begin
                obuf[obuf_tail] <= mem_rd_data;
                obuf_tail       <= !obuf_tail;
            end
            if (pop) begin
                obuf_head <= !obuf_head;
            end
            case ({push, pop})
                2'b10:   obuf_cnt <= obuf_cnt + 2'd1;
                2'b01:   obuf_cnt <= obuf_cnt - 2'd1;
                default: obuf_cnt <= obuf_cnt;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge rd_clk) disable iff (!rst_)
        !(push && (obuf_cnt == 2'd2) && !pop));

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb/tb_fifo_rd_ctrl.sv - self-checking bench for fifo_rd_ctrl
module tb_fifo_rd_ctrl;

    localparam int AW = 4;
    localparam int DW = 4;
    localparam int PW = AW + 1;

    logic          rd_clk = 1'b0;
    logic          rst_ = 1'b0;
    logic [PW-1:0] wr_ptr_gray = '0;
    logic [PW-1:0] rd_ptr_gray;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [DW-1:0] mem_rd_data = '0;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [PW-1:0] rd_level;

    always #5 rd_clk = ~rd_clk;

    fifo_rd_ctrl dut (
        .rd_clk      (rd_clk),
        .rst_        (rst_),
        .wr_ptr_gray (wr_ptr_gray),
        .rd_ptr_gray (rd_ptr_gray),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .rd_level    (rd_level)
    );

    int errors = 0;
    int checks = 0;
    int issue_cnt = 0;
    int cur_wr = 0;
    logic [DW-1:0] sb[$];
    logic [AW-1:0] addr_q[$];

    typedef struct {
        logic ready;
        logic en;
        int   addr;
        logic valid;
        int   data;
        int   level;
    } vec_t;

    vec_t tbl[7];

    function automatic logic [DW-1:0] mem_val(input int a);
        return DW'(a + 1);
    endfunction

    function automatic logic [PW-1:0] to_gray(input int b);
        logic [PW-1:0] v;
        v = PW'(b);
        return v ^ (v >> 1);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // memory with 1-cycle read latency, contents addr+1
    always @(posedge rd_clk) begin
        if (mem_rd_en) mem_rd_data <= mem_val(int'(mem_rd_addr));
    end

    always @(negedge rd_clk) begin
        if (rst_ === 1'b1) begin
            if (mem_rd_en) begin
                issue_cnt++;
                if (addr_q.size() == 0) chk("issue_expected", 0, 1);
                else chk("rd_addr", int'(mem_rd_addr), int'(addr_q.pop_front()));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) chk("pop_expected", 0, 1);
                else chk("out_data", int'(out_data), int'(sb.pop_front()));
            end
        end
    end

    task automatic advance_wr(input int target);
        for (int a = cur_wr; a < target; a++) begin
            sb.push_back(mem_val(a % 16));
            addr_q.push_back(AW'(a % 16));
        end
        cur_wr = target;
        wr_ptr_gray = to_gray(target % 32);
    endtask

    task automatic do_reset();
        @(posedge rd_clk); #1;
        rst_ = 1'b0;
        wr_ptr_gray = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge rd_clk);
        #1;
        sb.delete();
        addr_q.delete();
        cur_wr = 0;
        rst_ = 1'b1;
    endtask

    task automatic drain(input string name, input int max);
        int n;
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < max) begin
            @(posedge rd_clk); #1;
            n++;
        end
        chk(name, sb.size(), 0);
        chk({name, "_addr"}, addr_q.size(), 0);
    endtask

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        tbl[0] = '{ready: 1'b1, en: 1'b0, addr: 0, valid: 1'b0, data: 0, level: 0};
        tbl[1] = '{ready: 1'b1, en: 1'b1, addr: 0, valid: 1'b0, data: 0, level: 3};
        tbl[2] = '{ready: 1'b1, en: 1'b1, addr: 1, valid: 1'b0, data: 0, level: 2};
        tbl[3] = '{ready: 1'b1, en: 1'b1, addr: 2, valid: 1'b1, data: 1, level: 1};
        tbl[4] = '{ready: 1'b1, en: 1'b0, addr: 3, valid: 1'b1, data: 2, level: 0};
        tbl[5] = '{ready: 1'b1, en: 1'b0, addr: 3, valid: 1'b1, data: 3, level: 0};
        tbl[6] = '{ready: 1'b1, en: 1'b0, addr: 3, valid: 1'b0, data: 0, level: 0};

        // reset with a nonzero write pointer present
        rst_ = 1'b0;
        wr_ptr_gray = 5'b00101;
        out_ready = 1'b0;
        repeat (2) @(posedge rd_clk);
        @(negedge rd_clk);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_mem_rd_en", int'(mem_rd_en), 0);
        chk("rst_rd_ptr_gray", int'(rd_ptr_gray), 0);
        chk("rst_rd_level", int'(rd_level), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_mem_rd_addr", int'(mem_rd_addr), 0);
        wr_ptr_gray = '0;
        @(posedge rd_clk); #1;
        rst_ = 1'b1;

        // basic read, cycle-exact
        out_ready = 1'b1;
        repeat (2) @(posedge rd_clk);
        #1;
        advance_wr(3);
        for (int i = 0; i < 7; i++) begin
            @(posedge rd_clk); #1;
            out_ready = tbl[i].ready;
            @(negedge rd_clk);
            chk($sformatf("basic_en[%0d]", i), int'(mem_rd_en), int'(tbl[i].en));
            chk($sformatf("basic_addr[%0d]", i), int'(mem_rd_addr), tbl[i].addr);
            chk($sformatf("basic_valid[%0d]", i), int'(out_valid), int'(tbl[i].valid));
            chk($sformatf("basic_level[%0d]", i), int'(rd_level), tbl[i].level);
            if (tbl[i].valid) chk($sformatf("basic_data[%0d]", i), int'(out_data), tbl[i].data);
        end
        drain("basic_drain", 20);
        chk("basic_gray", int'(rd_ptr_gray), 2);
        chk("basic_level_end", int'(rd_level), 0);

        // back-pressure
        do_reset();
        issue_cnt = 0;
        advance_wr(5);
        repeat (10) @(negedge rd_clk);
        chk("bp_issues", issue_cnt, 2);
        chk("bp_en", int'(mem_rd_en), 0);
        chk("bp_valid", int'(out_valid), 1);
        chk("bp_level", int'(rd_level), 3);
        for (int i = 0; i < 3; i++) begin
            @(negedge rd_clk);
            chk($sformatf("bp_hold[%0d]", i), int'(out_data), 1);
        end
        @(posedge rd_clk); #1;
        out_ready = 1'b1;
        drain("bp_drain", 40);
        chk("bp_issues_total", issue_cnt, 5);

        // wrap-around
        advance_wr(14);
        drain("wrap_pre_drain", 40);
        issue_cnt = 0;
        advance_wr(18);
        drain("wrap_drain", 40);
        chk("wrap_issues", issue_cnt, 4);
        chk("wrap_gray", int'(rd_ptr_gray), 27);
        chk("wrap_level", int'(rd_level), 0);

        // full memory
        do_reset();
        issue_cnt = 0;
        advance_wr(16);
        repeat (2) @(posedge rd_clk);
        @(negedge rd_clk);
        chk("full_level16", int'(rd_level), 16);
        repeat (6) @(negedge rd_clk);
        chk("full_level14", int'(rd_level), 14);
        chk("full_issues", issue_cnt, 2);
        chk("full_en", int'(mem_rd_en), 0);
        chk("full_data", int'(out_data), 1);
        @(posedge rd_clk); #1;
        out_ready = 1'b1;
        drain("full_drain", 60);
        chk("full_issues_total", issue_cnt, 16);
        chk("full_level_end", int'(rd_level), 0);

        // reset while one word is buffered and one is returning
        out_ready = 1'b0;
        advance_wr(18);
        repeat (3) @(posedge rd_clk);
        @(negedge rd_clk);
        chk("mid_pre_en", int'(mem_rd_en), 1);
        chk("mid_pre_valid", int'(out_valid), 0);
        @(posedge rd_clk); #1;
        rst_ = 1'b0;
        wr_ptr_gray = '0;
        cur_wr = 0;
        sb.delete();
        addr_q.delete();
        @(negedge rd_clk);
        chk("mid_buffered", int'(out_valid), 1);
        @(posedge rd_clk); #1;
        rst_ = 1'b1;
        @(negedge rd_clk);
        chk("mid_valid", int'(out_valid), 0);
        chk("mid_gray", int'(rd_ptr_gray), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge rd_clk);
            chk($sformatf("mid_dropped[%0d]", i), int'(out_valid), 0);
            chk($sformatf("mid_idle[%0d]", i), int'(mem_rd_en), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
